// File: rtl/conv1_window.sv
// conv1_window: raster-scan 3x3 window generator feeding the conv1 filter bank.
// Two line buffers (LB1 = row r-2, LB0 = row r-1) indexed by column, plus a
// two-column shift window; the incoming column completes the 3x3 neighbourhood.
// Optional macro CONV1_WIN_SOF_EN adds a frame_start input that forces the
// accepted pixel to position (0,0).
module conv1_window #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pixel_in,
  input  logic              pixel_valid,
`ifdef CONV1_WIN_SOF_EN
  input  logic              frame_start,
`endif
  output logic [DATA_W-1:0] data_out [0:8],
  output logic              valid_out,
  output logic              frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [CW-1:0]     w_col;
  logic [RW-1:0]     w_row;
  logic              w_sof;
  logic              w_emit;
  logic              w_last;
  logic [DATA_W-1:0] r_lb1 [0:IMG_W-1];
  logic [DATA_W-1:0] r_lb0 [0:IMG_W-1];
  // r_sw[0] = column c-2, r_sw[1] = column c-1; index 0..2 = rows r-2..r
  logic [DATA_W-1:0] r_sw [0:1][0:2];
  logic [DATA_W-1:0] w_newcol [0:2];

`ifdef CONV1_WIN_SOF_EN
  assign w_sof = frame_start;
`else
  assign w_sof = 1'b0;
`endif

  // Effective position of the pixel being accepted (start-of-frame overrides counters)
  always_comb begin
    w_col  = w_sof ? '0 : r_col;
    w_row  = w_sof ? '0 : r_row;
    w_emit = (w_row >= RW'(2)) && (w_col >= CW'(2));
    w_last = (w_row == LAST_ROW) && (w_col == LAST_COL);
  end

  // New rightmost window column: rows r-2, r-1 from line buffers, row r from input
  always_comb begin
    w_newcol[0] = r_lb1[w_col];
    w_newcol[1] = r_lb0[w_col];
    w_newcol[2] = pixel_in;
  end

  // Line buffers roll down one row at the accepted column; contents are not reset
  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      r_lb1[w_col] <= r_lb0[w_col];
      r_lb0[w_col] <= pixel_in;
    end
  end

  // Raster position counters, wrapping at end of line and end of frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (pixel_valid) begin
      if (w_col == LAST_COL) begin
        r_col <= '0;
        r_row <= (w_row == LAST_ROW) ? '0 : w_row + 1'b1;
      end else begin
        r_col <= w_col + 1'b1;
        r_row <= w_row;
      end
    end
  end

  // Shift window advances one column per accepted pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw <= '{default: '0};
    end else if (pixel_valid) begin
      r_sw[0] <= r_sw[1];
      r_sw[1] <= w_newcol;
    end
  end

  // Register complete windows and the valid/frame_done strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '{default: '0};
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= pixel_valid && w_emit;
      frame_done <= pixel_valid && w_emit && w_last;
      if (pixel_valid && w_emit) begin
        data_out[0] <= r_sw[0][0];
        data_out[1] <= r_sw[1][0];
        data_out[2] <= w_newcol[0];
        data_out[3] <= r_sw[0][1];
        data_out[4] <= r_sw[1][1];
        data_out[5] <= w_newcol[1];
        data_out[6] <= r_sw[0][2];
        data_out[7] <= r_sw[1][2];
        data_out[8] <= w_newcol[2];
      end
    end
  end

endmodule

// File: doc/conv1_window.md
# conv1_window

Upstream feeder for the conv1 filter bank. Accepts a raster-scan stream of 32-bit pixels, one per cycle, and keeps two line buffers plus a 3x3 shift window. For every pixel that completes a full 3x3 neighbourhood, it presents that neighbourhood as nine words, 1 cycle after the pixel is accepted. Output feeds the conv1 compute stage's `data_out[0:8]`/`valid_in` directly; valid (unpadded) convolution, stride 1.

## Interface
- `IMG_W`, 28, pixels per line (≥3)
- `IMG_H`, 28, lines per frame (≥3)
- `DATA_W`, 32, pixel width; content is opaque (no arithmetic performed)

- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  reset: one clock; reset is asynchronous and active-low
- `pixel_in`  in  DATA_W  incoming pixel
- `pixel_valid`  in  1  pixel_in valid this cycle; no backpressure, every valid cycle is consumed
- `frame_start`  in  1  present only with `CONV1_WIN_SOF_EN` (see Configuration)
- `data_out[0:8]`  out  DATA_W each  3x3 window, row-major: [0]=(r-2,c-2) … [8]=(r,c)
- `valid_out`  out  1  data_out holds a complete window this cycle
- `frame_done`  out  1  1-cycle pulse with the last window of a frame

## Operation
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) track the position of the next accepted pixel.
  - `col` advances on each valid pixel.
  - At `col`=IMG_W-1, `col` wraps to 0 and `row` increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0; the next pixel starts a new frame with no idle cycle required.
- Line buffers LB1 and LB0, each IMG_W deep, are indexed by `col`.
  - On an accepted pixel at `col`=c: window column c is formed from {LB1[c], LB0[c], pixel_in}, i.e. rows r-2, r-1, r.
  - In the same cycle, LB1[c]←LB0[c] and LB0[c]←pixel_in.
  - LB contents are not reset.
- Shift window: 3 columns of 3 words. On each accepted pixel, columns shift left and the new column enters at the right.
  - The shift is not cleared at line start; windows with c<2 are never emitted, so stale columns are harmless.
- Emission: when accepted pixel has `row`≥2 and `col`≥2, register the window into `data_out` and set `valid_out`=1 next cycle. Otherwise `valid_out`=0 next cycle, and `data_out` holds its last value.
- Windows per frame: (IMG_W-2)*(IMG_H-2).
- `frame_done`=1 in the same cycle as `valid_out` for the window whose [8] is pixel (IMG_H-1, IMG_W-1).
- Gaps (`pixel_valid`=0): no state changes except `valid_out`/`frame_done` drop to 0.

## Timing
- Reset values: `valid_out`=0, `frame_done`=0, all `data_out` words=0, `row`=`col`=0, shift window=0.
- Latency: exactly 1 cycle from accepting pixel (r,c) to the corresponding `valid_out`.
- Throughput: 1 window/cycle sustained. Back-to-back frames are supported.
- Reset asserted mid-frame: outputs take reset values immediately (asynchronously). After release, the next valid pixel is (0,0); no partial window from the aborted frame is ever emitted.
- Wrap and emit coincide: the last pixel of a frame both emits the final window and wraps the counters in the same cycle.

## Configuration
- `CONV1_WIN_SOF_EN` defined:
  - Adds input `frame_start`.
  - An accepted pixel with `frame_start`=1 is treated as (0,0): counters are forced, and the pixel is processed as col 0 / row 0 (no emission).
  - `frame_start` without `pixel_valid` is ignored.
  - Resynchronises after upstream drops or extra pixels.
- Undefined: port absent; position is tracked purely by the counters.

## Test plan
- IMG_W=5, IMG_H=4, pixel = row*16+col, continuous valid:
  - First `valid_out` occurs 1 cycle after the 13th pixel, with data_out = {00,01,02,10,11,12,20,21,22}.
  - Exactly 6 windows are emitted.
  - The last window is {12,13,14,22,23,24,32,33,34}, with `frame_done`=1 in that cycle only.
- Same frame with `pixel_valid` toggled 1-0-0-1 randomly: identical 6 windows in the same order; `valid_out` is never 1 in a cycle following an idle input cycle.
- Two frames back-to-back, the second using pixel+0x100: 12 windows total. The first window of frame 2 is {100,101,102,110,…,122}, with no window mixing frame 1 rows.
- Reset pulsed after 9 pixels, then a full frame: outputs are 0 during reset, and exactly 6 correct windows follow.
- With `CONV1_WIN_SOF_EN`: 3 junk pixels, then a frame whose first pixel carries `frame_start`=1. Exactly 6 correct windows result, with `frame_done` on the last.
